// File: rtl/fast_pkg.sv
// Shared types for the FAST corner post-processing blocks.
//   coord_t        : pixel coordinate
//   corner_entry_t : one collector FIFO entry {x, y, last, dummy}
//   coll_state_t   : collector frame-tracking state
package fast_pkg;
  localparam int COORD_W = 10;
  localparam int COL_NUM = 640;
  localparam int ROW_NUM = 480;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
    logic   last;
    logic   dummy;
  } corner_entry_t;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    ACTIVE   = 1'b1
  } coll_state_t;
endpackage

// File: rtl/fast_sync_fifo.sv
// Synchronous show-ahead FIFO, generic over entry width and depth.
// Ports:
//   clk, rst (sync, active low)
//   push/din   : write when not full, or when full together with a pop
//   pop/dout   : dout is the head entry; pop ignored when empty
//   full, empty, level (occupancy, clog2(DEPTH)+1 bits)
module fast_sync_fifo #(
  parameter  int WIDTH = 22,
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    cnt;
  logic             do_push, do_pop;

  assign full    = (cnt == LW'(DEPTH));
  assign empty   = (cnt == '0);
  assign level   = cnt;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + LW'(1);
        2'b01:   cnt <= cnt - LW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/fast_corner_collector.sv
// Collects corners from the non-stallable FAST/NMS stream into a FIFO and
// streams them out over valid/ready, one end-of-frame token per frame.
// Ports:
//   clk, rst (sync, active low)
//   in_valid, iscorner, x_coord, y_coord : pixel stream (no backpressure)
//   out_valid/out_ready, out_x, out_y, out_last, out_dummy : corner stream
//   frame_corners : corners accepted in the last completed frame
//   frame_err     : sticky, a frame restarted before its end-of-frame
// Optional (macro FAST_COLLECT_STATS_EN):
//   drop_cnt       : corners dropped in the last finished frame (saturating)
//   fifo_max_level : occupancy high-water mark since reset
module fast_corner_collector #(
  parameter  int COL_NUM     = 640,
  parameter  int ROW_NUM     = 480,
  parameter  int COORD_W     = 10,
  parameter  int FIFO_DEPTH  = 64,
  parameter  int MAX_CORNERS = 1023,
  localparam int CW          = $clog2(MAX_CORNERS + 1),
  localparam int LW          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               iscorner,
  input  logic [COORD_W-1:0] x_coord,
  input  logic [COORD_W-1:0] y_coord,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COORD_W-1:0] out_x,
  output logic [COORD_W-1:0] out_y,
  output logic               out_last,
  output logic               out_dummy,
  output logic [CW-1:0]      frame_corners,
  output logic               frame_err
`ifdef FAST_COLLECT_STATS_EN
  ,
  output logic [15:0]        drop_cnt,
  output logic [LW-1:0]      fifo_max_level
`endif
);
  import fast_pkg::*;

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(COL_NUM - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(ROW_NUM - 1);

  coll_state_t   state, state_n;
  logic [CW-1:0] cnt, cnt_n, cnt_base, fc_n;
  logic          err_n;
  logic          sof, eof, restart, live, accept;
  logic          push, pop, full, empty;
  logic [LW-1:0] level;
  corner_entry_t din, head;

  assign sof     = in_valid && (x_coord == '0) && (y_coord == '0);
  assign eof     = in_valid && (x_coord == X_LAST) && (y_coord == Y_LAST);
  assign restart = (state == ACTIVE) && sof;
  // Pixel evaluated as part of a frame (the SOF pixel of a fresh frame too).
  assign live    = in_valid && !restart && ((state == ACTIVE) || sof);
  // A fresh SOF starts counting from zero on the same pixel.
  assign cnt_base = (state == ACTIVE) ? cnt : '0;
  // Keep one slot free so the end-of-frame token can always be pushed.
  assign accept  = live && iscorner && (cnt_base < CW'(MAX_CORNERS)) &&
                   (level <= LW'(FIFO_DEPTH - 2));

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    fc_n    = frame_corners;
    err_n   = frame_err;
    push    = 1'b0;
    din     = '0;
    if (restart) begin
      // Close the aborted frame; a corner on this pixel is dropped.
      push      = !full;
      din.last  = 1'b1;
      din.dummy = 1'b1;
      cnt_n     = '0;
      err_n     = 1'b1;
    end else if (live) begin
      state_n = ACTIVE;
      cnt_n   = cnt_base + CW'(accept);
      if (eof) begin
        push      = !full;
        din.last  = 1'b1;
        din.dummy = !accept;
        if (accept) begin
          din.x = x_coord;
          din.y = y_coord;
        end
        fc_n    = cnt_n;
        state_n = WAIT_SOF;
      end else if (accept) begin
        push  = 1'b1;
        din.x = x_coord;
        din.y = y_coord;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= WAIT_SOF;
      cnt           <= '0;
      frame_corners <= '0;
      frame_err     <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      frame_corners <= fc_n;
      frame_err     <= err_n;
    end
  end

  fast_sync_fifo #(
    .WIDTH($bits(corner_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  // Mask the head so outputs read as zero while nothing is buffered.
  assign out_x     = out_valid ? head.x     : '0;
  assign out_y     = out_valid ? head.y     : '0;
  assign out_last  = out_valid && head.last;
  assign out_dummy = out_valid && head.dummy;

`ifdef FAST_COLLECT_STATS_EN
  logic [15:0] drop_cur, drop_sum;
  logic        drop;

  assign drop     = live && iscorner && !accept;
  assign drop_sum = (drop && (drop_cur != 16'hFFFF)) ? drop_cur + 16'd1 : drop_cur;

  always_ff @(posedge clk) begin
    if (!rst) begin
      drop_cur       <= '0;
      drop_cnt       <= '0;
      fifo_max_level <= '0;
    end else begin
      if (push && din.last) begin
        drop_cnt <= drop_sum;
        drop_cur <= '0;
      end else begin
        drop_cur <= drop_sum;
      end
      if (level > fifo_max_level) fifo_max_level <= level;
    end
  end
`endif
endmodule

// File: tb/tb_fast_corner_collector.sv
module tb_fast_corner_collector;
  localparam int DEPTH = 4;
  localparam int MAXC  = 4;
  localparam int CW    = $clog2(MAXC + 1);
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk, rst;
  logic          in_valid, iscorner, out_ready;
  logic [9:0]    x_coord, y_coord, out_x, out_y;
  logic          out_valid, out_last, out_dummy, frame_err;
  logic [CW-1:0] frame_corners;
`ifdef FAST_COLLECT_STATS_EN
  logic [15:0]   drop_cnt;
  logic [LW-1:0] fifo_max_level;
`endif

  fast_corner_collector #(
    .COL_NUM(640), .ROW_NUM(480), .COORD_W(10),
    .FIFO_DEPTH(DEPTH), .MAX_CORNERS(MAXC)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .iscorner(iscorner),
    .x_coord(x_coord), .y_coord(y_coord), .out_valid(out_valid),
    .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
    .out_last(out_last), .out_dummy(out_dummy),
    .frame_corners(frame_corners), .frame_err(frame_err)
`ifdef FAST_COLLECT_STATS_EN
    , .drop_cnt(drop_cnt), .fifo_max_level(fifo_max_level)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queue of expected entries plus frame bookkeeping.
  typedef struct { int x; int y; bit last; bit dummy; } ent_t;
  ent_t q[$];
  bit   m_active, m_err;
  int   m_cnt, m_fc, m_drop_cur, m_drop, m_max;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    ent_t h;
    bit   v;
    v = q.size() > 0;
    h = '{x: 0, y: 0, last: 0, dummy: 0};
    if (v) h = q[0];
    chk({tag, ".valid"}, out_valid, v);
    chk({tag, ".x"}, out_x, h.x);
    chk({tag, ".y"}, out_y, h.y);
    chk({tag, ".last"}, out_last, h.last);
    chk({tag, ".dummy"}, out_dummy, h.dummy);
    chk({tag, ".fc"}, frame_corners, m_fc);
    chk({tag, ".err"}, frame_err, m_err);
`ifdef FAST_COLLECT_STATS_EN
    chk({tag, ".drop"}, drop_cnt, m_drop);
    chk({tag, ".maxlvl"}, fifo_max_level, m_max);
`endif
  endtask

  function automatic void m_drop_one();
    if (m_drop_cur < 65535) m_drop_cur++;
  endfunction

  task automatic step(input string tag, input bit v, input bit c,
                      input int x, input int y, input bit rdy);
    int   size0;
    bit   popq, ok, do_push;
    ent_t e;
    in_valid  = v;
    iscorner  = c;
    x_coord   = 10'(x);
    y_coord   = 10'(y);
    out_ready = rdy;
    @(posedge clk);
    size0   = q.size();
    popq    = rdy && size0 > 0;
    do_push = 0;
    e       = '{x: 0, y: 0, last: 0, dummy: 0};
    if (size0 > m_max) m_max = size0;
    if (v) begin
      if (m_active && x == 0 && y == 0) begin
        m_err = 1; m_cnt = 0;
        e = '{x: 0, y: 0, last: 1, dummy: 1}; do_push = 1;
        m_drop = m_drop_cur; m_drop_cur = 0;
      end else if (m_active || (x == 0 && y == 0)) begin
        if (!m_active) m_cnt = 0;
        m_active = 1;
        ok = c && m_cnt < MAXC && (DEPTH - size0) >= 2;
        if (ok) m_cnt++;
        if (c && !ok) m_drop_one();
        if (x == 639 && y == 479) begin
          e = ok ? '{x: x, y: y, last: 1, dummy: 0} : '{x: 0, y: 0, last: 1, dummy: 1};
          do_push = 1;
          m_fc = m_cnt; m_active = 0;
          m_drop = m_drop_cur; m_drop_cur = 0;
        end else if (ok) begin
          e = '{x: x, y: y, last: 0, dummy: 0}; do_push = 1;
        end
      end
    end
    if (popq) void'(q.pop_front());
    if (do_push) q.push_back(e);
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0; in_valid = 1'b0; iscorner = 1'b0;
    @(posedge clk);
    q.delete();
    m_active = 0; m_err = 0; m_cnt = 0; m_fc = 0;
    m_drop_cur = 0; m_drop = 0; m_max = 0;
    #1;
    rst = 1'b1;
    check_outputs(tag);
  endtask

  initial begin
    rst = 1'b0; in_valid = 0; iscorner = 0; x_coord = 0; y_coord = 0; out_ready = 0;
    do_reset("rst0");
    do_reset("rst1");

    // Three corners, last one on the EOF pixel.
    step("a_sof", 1, 0, 0, 0, 1);
    step("a_c1", 1, 1, 5, 3, 1);
    step("a_c2", 1, 1, 100, 200, 1);
    chk("a_head_x", out_x, 100);
    step("a_eof", 1, 1, 639, 479, 1);
    chk("a_eof_last", out_last, 1);
    chk("a_eof_dummy", out_dummy, 0);
    chk("a_fc", frame_corners, 3);
    step("a_idle", 0, 0, 0, 0, 1);

    // Empty frame: only a dummy end token.
    step("b_sof", 1, 0, 0, 0, 1);
    step("b_px", 1, 0, 7, 7, 1);
    step("b_eof", 1, 0, 639, 479, 1);
    chk("b_dummy", out_dummy, 1);
    chk("b_fc", frame_corners, 0);
    step("b_idle", 0, 0, 0, 0, 1);

    // Cap: 10 corners, only MAXC forwarded.
    step("c_sof", 1, 0, 0, 0, 1);
    for (int i = 1; i <= 10; i++) step("c_cr", 1, 1, i, 1, 1);
    step("c_eof", 1, 0, 639, 479, 1);
    chk("c_fc", frame_corners, 4);
`ifdef FAST_COLLECT_STATS_EN
    chk("c_drop", drop_cnt, 6);
`endif
    step("c_idle", 0, 0, 0, 0, 1);

    // FIFO pressure with consumer stalled.
    step("d_sof", 1, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) step("d_cr", 1, 1, 10 + i, 2, 0);
    step("d_eof", 1, 0, 639, 479, 0);
    chk("d_level", q.size(), 4);
    for (int i = 0; i < 5; i++) step("d_drain", 0, 0, 0, 0, 1);

    // Restart before EOF.
    step("e_sof", 1, 0, 0, 0, 1);
    step("e_c1", 1, 1, 3, 4, 1);
    step("e_c2", 1, 1, 5, 6, 1);
    step("e_restart", 1, 1, 0, 0, 1);
    chk("e_err", frame_err, 1);
    step("e_c3", 1, 1, 8, 9, 1);
    step("e_eof", 1, 0, 639, 479, 1);
    chk("e_fc", frame_corners, 1);
    step("e_idle", 0, 0, 0, 0, 1);

    // Reset with entries buffered.
    step("f_sof", 1, 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) step("f_cr", 1, 1, i, 3, 0);
    step("f_eof", 1, 0, 639, 479, 0);
    do_reset("f_rst");
    chk("f_valid", out_valid, 0);
    step("f_ign1", 1, 1, 20, 20, 1);
    step("f_ign2", 1, 1, 639, 479, 1);
    chk("f_ign_valid", out_valid, 0);
    step("f_sof2", 1, 1, 0, 0, 1);
    step("f_idle", 0, 0, 0, 0, 1);

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      int sel, rx, ry;
      sel = $urandom_range(0, 15);
      rx  = $urandom_range(0, 639);
      ry  = $urandom_range(0, 479);
      if (sel == 0) begin rx = 0; ry = 0; end
      else if (sel == 1) begin rx = 639; ry = 479; end
      if ($urandom_range(0, 299) == 0) do_reset("r_rst");
      else step("rnd", $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                rx, ry, $urandom_range(0, 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
